// File: rtl/ram_dma_if.sv
// Bus bundle between a RAM DMA engine and its requester/RAM side.
// master: drives the transfer request (start/op/src/dst/len/fill_val/abort)
//         and the RAM read data (mem_out); observes status and RAM controls.
// slave : the DMA engine; observes the request and mem_out, drives
//         busy/done/words_done and the RAM controls (mem_address/mem_load/mem_in).
interface ram_dma_if #(
  parameter int ADDR_W = 16
);
  logic                     start;
  logic                     op;
  logic        [ADDR_W-1:0] src;
  logic        [ADDR_W-1:0] dst;
  logic        [ADDR_W-1:0] len;
  logic signed [15:0]       fill_val;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic        [ADDR_W-1:0] words_done;
  logic        [15:0]       mem_address;
  logic                     mem_load;
  logic signed [15:0]       mem_in;
  logic signed [15:0]       mem_out;

  modport master (
    output start, op, src, dst, len, fill_val, abort, mem_out,
    input  busy, done, words_done, mem_address, mem_load, mem_in
  );

  modport slave (
    input  start, op, src, dst, len, fill_val, abort, mem_out,
    output busy, done, words_done, mem_address, mem_load, mem_in
  );
endinterface

// File: rtl/ram_dma.sv
// RAM DMA engine: copies len words from src to dst (2 cycles/word) or fills
// len words at dst with fill_val (1 cycle/word) in ascending address order.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - ram_dma_if.slave: request, status and RAM port signals
// Every output is a register; nothing combinational reaches busy/done/mem_*.
//
// state | meaning
// IDLE  | waiting for start
// READ  | source word presented on mem_address, captured at the edge
// WRITE | destination word written at the edge
// DONE  | one-cycle completion pulse
module ram_dma #(
  parameter int ADDR_W = 16
) (
  input logic       clk,
  input logic       rst_n,
  ram_dma_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                   state;
  logic                     op_r;
  logic        [ADDR_W-1:0] src_ptr;
  logic        [ADDR_W-1:0] dst_ptr;
  logic        [ADDR_W-1:0] len_r;
  logic        [ADDR_W-1:0] words_done;
  logic        [ADDR_W-1:0] wd_next;
  logic        [ADDR_W-1:0] src_nxt;
  logic        [ADDR_W-1:0] dst_nxt;
  logic                     busy;
  logic                     done;
  logic        [15:0]       mem_address;
  logic                     mem_load;
  logic signed [15:0]       mem_in;

  assign wd_next = words_done + ADDR_W'(1);
  assign src_nxt = src_ptr + ADDR_W'(1);
  assign dst_nxt = dst_ptr + ADDR_W'(1);

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.words_done  = words_done;
  assign bus.mem_address = mem_address;
  assign bus.mem_load    = mem_load;
  assign bus.mem_in      = mem_in;

  // mem_in doubles as the data holding register: it is loaded only when
  // entering WRITE (read word for copy, fill word for fill) and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      len_r       <= '0;
      words_done  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= '0;
      mem_load    <= 1'b0;
      mem_in      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r       <= bus.op;
            src_ptr    <= bus.src;
            dst_ptr    <= bus.dst;
            len_r      <= bus.len;
            words_done <= '0;
            if (bus.len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bus.op) begin
              state       <= WRITE;
              busy        <= 1'b1;
              mem_load    <= 1'b1;
              mem_address <= 16'(bus.dst);
              mem_in      <= bus.fill_val;
            end else begin
              state       <= READ;
              busy        <= 1'b1;
              mem_address <= 16'(bus.src);
            end
          end
        end
        READ: begin
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state       <= WRITE;
            mem_load    <= 1'b1;
            mem_address <= 16'(dst_ptr);
            mem_in      <= bus.mem_out;
          end
        end
        WRITE: begin
          // The write presented this cycle lands at this edge even on abort,
          // so it is always counted.
          words_done <= wd_next;
          src_ptr    <= src_nxt;
          dst_ptr    <= dst_nxt;
          if (bus.abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            mem_load <= 1'b0;
          end else if (wd_next == len_r) begin
            state    <= DONE;
            busy     <= 1'b0;
            mem_load <= 1'b0;
            done     <= 1'b1;
          end else if (op_r) begin
            mem_address <= 16'(dst_nxt);
          end else begin
            state       <= READ;
            mem_load    <= 1'b0;
            mem_address <= 16'(src_nxt);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_dma.sv
module tb_ram_dma;
  logic clk;
  logic rst_n;

  ram_dma_if #(.ADDR_W(16)) bus();

  ram_dma #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic signed [15:0] ram     [0:65535] = '{default: 16'sd0};
  logic signed [15:0] exp_ram [0:65535] = '{default: 16'sd0};
  logic               pre_we;
  logic        [15:0] pre_a;
  logic signed [15:0] pre_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;
  end

  assign bus.mem_out = ram[bus.mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic signed [15:0] v);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = v;
    exp_ram[a] = v;
    tick();
    pre_we = 1'b0;
  endtask

  // Reference: transfer is a plain sequential loop over words; the cycle
  // schedule follows from the throughput rules (fill 1 cycle/word from
  // cycle 1, copy read/write pairs from cycle 1, done right after).
  task automatic run_xfer(input bit opi, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input logic signed [15:0] fv,
                          input bit ab0, input bit hammer);
    logic        [15:0] ea [$];
    logic signed [15:0] ed [$];
    int done_cyc;
    for (int i = 0; i < int'(n); i++) begin
      logic        [15:0] a;
      logic signed [15:0] w;
      a = d + 16'(i);
      w = opi ? fv : exp_ram[s + 16'(i)];
      exp_ram[a] = w;
      ea.push_back(a);
      ed.push_back(w);
    end
    done_cyc = (n == 0) ? 1 : (opi ? int'(n) + 1 : 2 * int'(n) + 1);

    bus.start = 1'b1; bus.op = opi; bus.src = s; bus.dst = d; bus.len = n;
    bus.fill_val = fv; bus.abort = ab0;
    tick();
    bus.abort = 1'b0;
    bus.start = hammer;
    bus.op = ~opi;
    bus.src = 16'($urandom);
    bus.dst = 16'($urandom);
    bus.len = 16'($urandom_range(1, 9));
    bus.fill_val = 16'($urandom);

    for (int c = 1; c <= done_cyc; c++) begin
      bit is_wr;
      int idx;
      is_wr = opi ? (c <= int'(n)) : ((c % 2 == 0) && (c <= 2 * int'(n)));
      idx   = opi ? c - 1 : c / 2 - 1;
      chk("mem_load", 32'(bus.mem_load), 32'(is_wr));
      if (is_wr) begin
        chk("wr_addr", 32'(bus.mem_address), 32'(ea[idx]));
        chk("wr_data", 32'(bus.mem_in), 32'(ed[idx]));
      end else if (!opi && c < done_cyc) begin
        chk("rd_addr", 32'(bus.mem_address), 32'(s + 16'((c - 1) / 2)));
      end
      chk("busy", 32'(bus.busy), 32'(c < done_cyc));
      chk("done", 32'(bus.done), 32'(c == done_cyc));
      tick();
    end
    bus.start = 1'b0;
    chk("done_after", 32'(bus.done), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("load_after", 32'(bus.mem_load), 32'd0);
    chk("words_done", 32'(bus.words_done), 32'(n));
    for (int i = -1; i <= int'(n); i++)
      chk("ram_dst", 32'(ram[d + 16'(i)]), 32'(exp_ram[d + 16'(i)]));
  endtask

  initial begin
    rst_n = 1'b0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.start = 1'b0; bus.op = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    bus.fill_val = '0; bus.abort = 1'b0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wd", 32'(bus.words_done), 32'd0);
    chk("rst_load", 32'(bus.mem_load), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_min", 32'(bus.mem_in), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // fill dst=100 len=3
    run_xfer(1'b1, 16'd0, 16'd100, 16'd3, 16'sd4321, 1'b0, 1'b0);
    // copy 10->20 len=2
    poke(16'd10, 16'sd12345);
    poke(16'd11, -16'sd7);
    run_xfer(1'b0, 16'd10, 16'd20, 16'd2, 16'sd0, 1'b0, 1'b0);
    // len=0
    run_xfer(1'b0, 16'd5, 16'd500, 16'd0, 16'sd0, 1'b0, 1'b0);
    // address wrap
    run_xfer(1'b1, 16'd0, 16'hFFFF, 16'd2, -16'sd1, 1'b0, 1'b0);
    // start with abort in IDLE is accepted; start held high while busy
    run_xfer(1'b1, 16'd0, 16'd700, 16'd4, 16'sd99, 1'b1, 1'b1);

    // abort in cycle 3 of fill dst=0 len=5, ignored start in cycle 2
    poke(16'd3, 16'sh1111);
    poke(16'd4, 16'sh2222);
    bus.start = 1'b1; bus.op = 1'b1; bus.dst = 16'd0; bus.len = 16'd5; bus.fill_val = 16'sd555;
    tick();
    bus.start = 1'b0;
    chk("ab_c1_addr", 32'(bus.mem_address), 32'd0);
    tick();
    bus.start = 1'b1; bus.op = 1'b0; bus.src = 16'd50; bus.dst = 16'd60; bus.len = 16'd2;
    chk("ab_c2_addr", 32'(bus.mem_address), 32'd1);
    tick();
    bus.start = 1'b0; bus.abort = 1'b1;
    chk("ab_c3_addr", 32'(bus.mem_address), 32'd2);
    chk("ab_c3_load", 32'(bus.mem_load), 32'd1);
    chk("ab_c3_wd", 32'(bus.words_done), 32'd2);
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_load", 32'(bus.mem_load), 32'd0);
    chk("ab_wd", 32'(bus.words_done), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("ab_nodone", 32'(bus.done), 32'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) exp_ram[i] = 16'sd555;
    for (int i = 0; i < 5; i++) chk("ab_ram", 32'(ram[i]), 32'(exp_ram[i]));

    // reset in cycle 3 of copy len=4
    for (int i = 0; i < 4; i++) poke(16'(200 + i), 16'($urandom));
    poke(16'd301, 16'sd11); poke(16'd302, 16'sd22); poke(16'd303, 16'sd33);
    bus.start = 1'b1; bus.op = 1'b0; bus.src = 16'd200; bus.dst = 16'd300; bus.len = 16'd4;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_load", 32'(bus.mem_load), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_addr", 32'(bus.mem_address), 32'd0);
    chk("mr_wd", 32'(bus.words_done), 32'd0);
    chk("mr_min", 32'(bus.mem_in), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("mr_idle_load", 32'(bus.mem_load), 32'd0);
      tick();
    end
    exp_ram[300] = exp_ram[200];
    for (int i = 0; i < 4; i++) chk("mr_ram", 32'(ram[300 + i]), 32'(exp_ram[300 + i]));

    // reset while a fill write is presented: that write must not land
    poke(16'd400, 16'sd77);
    bus.start = 1'b1; bus.op = 1'b1; bus.dst = 16'd400; bus.len = 16'd3; bus.fill_val = 16'sd1234;
    tick();
    bus.start = 1'b0;
    chk("wr_rst_pre", 32'(bus.mem_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst_load", 32'(bus.mem_load), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("wr_rst_ram", 32'(ram[400]), 32'(exp_ram[400]));

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      logic [15:0] s;
      logic [15:0] d;
      logic [15:0] n;
      bit          o;
      o = 1'($urandom_range(0, 1));
      n = 16'($urandom_range(0, 6));
      s = 16'($urandom);
      case ($urandom_range(0, 2))
        0: d = 16'($urandom);
        1: d = s + 16'($urandom_range(1, 3));
        default: d = s - 16'($urandom_range(1, 3));
      endcase
      for (int i = 0; i < int'(n); i++) poke(s + 16'(i), 16'($urandom));
      run_xfer(o, s, d, n, 16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter: ADDR_W, default 16, width of addresses, length and word counter; all address arithmetic is modulo 2^ADDR_W.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request a transfer; sampled only in IDLE.
REQ-005 op  in  1  0 = copy (src to dst), 1 = fill (fill_val to dst).
REQ-006 src, dst  in  ADDR_W each  start addresses, latched on start.
REQ-007 len  in  ADDR_W  word count, latched on start.
REQ-008 fill_val  in  16  signed fill word, latched on start.
REQ-009 abort  in  1  terminate the active transfer.
REQ-010 busy  out  1  high in READ/WRITE states.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 words_done  out  ADDR_W  words written in the current or last transfer.
REQ-013 mem_address  out  16  address to the RAM.
REQ-014 mem_load  out  1  RAM write enable.
REQ-015 mem_in  out  16  signed write data to the RAM.
REQ-016 mem_out  in  16  signed RAM read data.
REQ-017 The attached RAM writes mem_in at mem_address on a clk edge with mem_load=1; mem_out combinationally reflects mem_address.

Function
REQ-018 The FSM shall have the states IDLE, READ, WRITE and DONE.
REQ-019 Outputs shall come from registers only; no combinational path from any input to mem_* or busy/done.
REQ-020 In IDLE, start=1 latches the operands, clears words_done and moves to: DONE if len=0; READ if op=0; WRITE if op=1.
REQ-021 READ: mem_address=src pointer, mem_load=0; at the edge, capture mem_out, go to WRITE.
REQ-022 WRITE: mem_address=dst pointer, mem_load=1, mem_in=captured word (copy) or fill_val (fill); at the edge, increment words_done and the pointers.
REQ-023 After WRITE: if words_done reaches len, go to DONE; otherwise copy returns to READ and fill stays in WRITE.
REQ-024 Throughput: copy = 2 cycles/word; fill = 1 cycle/word; done is asserted in the cycle after the last write edge.
REQ-025 DONE: done=1 and busy=0 for one cycle, then IDLE; words_done holds until the next accepted start.
REQ-026 Pointers wrap from 2^ADDR_W-1 to 0 without error.
REQ-027 Copy proceeds in ascending order; overlapping regions give exactly the result of that sequential order.
REQ-028 start is ignored while busy or in DONE.
REQ-029 On abort in READ/WRITE, the next state is IDLE, no done pulse, and mem_load=0 from the next cycle.
REQ-030 A write already presented in the abort cycle still completes at that edge and is counted in words_done.
REQ-031 If start and abort are both high in IDLE, the start is accepted.
REQ-032 Outside WRITE, mem_load=0 and mem_in holds its last value.

Reset
REQ-033 rst_n=0 shall immediately force IDLE, busy=0, done=0, words_done=0, mem_load=0, mem_address=0, mem_in=0, and all internal registers to 0.
REQ-034 Reset mid-transfer discards the transfer, with no further writes.
REQ-035 Operation resumes on the first rising edge after rst_n=1.

Verification
REQ-036 Fill: op=1, dst=100, len=3, fill_val=4321 -> RAM[100..102]=4321 written in cycles 1-3, done in cycle 4, words_done=3.
REQ-037 Copy: RAM[10]=12345, RAM[11]=-7; src=10, dst=20, len=2 -> RAM[20]=12345, RAM[21]=-7, mem_load high in cycles 2 and 4, done in cycle 5.
REQ-038 len=0 with start -> done in cycle 1, mem_load never high, words_done=0.
REQ-039 Wrap: fill dst=16'hFFFF, len=2, fill_val=-1 -> writes at 16'hFFFF then 16'h0000.
REQ-040 Fill dst=0, len=5: abort in cycle 3 -> RAM[0..2] written, RAM[3..4] untouched, no done, words_done=3; a second start in cycle 2 is ignored.
REQ-041 Copy len=4: rst_n low in cycle 3 -> mem_load=0 immediately, busy=0, no further writes after release.
